// File: rtl/op_chain_pipe.sv
// Lane-wise unary-op chain: full mode latency STAGES, reduced mode latency 1, one word/cycle.
// Single global enable: out_valid & ~out_ready freezes every stage and drops in_ready.
module op_chain_pipe #(
   parameter int WIDTH  = 2,
   parameter int STAGES = 8,
   parameter int CNTW   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic                      cfg_we,
   input  logic [$clog2(STAGES)-1:0] cfg_idx,
   input  logic [1:0]                cfg_op,
   output logic                      cfg_err,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      busy,
   output logic [CNTW-1:0]           xfer_cnt
);

   localparam int IW = $clog2(STAGES);
   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_INV  = 2'b01;
   localparam logic [1:0] OP_F0   = 2'b10;
   localparam logic [1:0] OP_F1   = 2'b11;

   function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op, input logic [WIDTH-1:0] d);
      case (op)
         OP_INV:  apply_op = ~d;
         OP_F0:   apply_op = '0;
         OP_F1:   apply_op = '1;
         default: apply_op = d;
      endcase
   endfunction

   logic [1:0]       ops     [STAGES];
   logic [1:0]       ops_nxt [STAGES];
   logic [1:0]       red_op;
   logic [1:0]       red_nxt;
   logic             mode_q;
   logic [WIDTH-1:0] sdat    [STAGES];
   logic [STAGES-1:0] svld;
   logic             en;
   logic             acc;
   logic             idle;
   logic             idx_ok;
   logic             cfg_ok;

   assign out_valid = mode_q ? svld[0] : svld[STAGES-1];
   assign out_data  = mode_q ? sdat[0] : sdat[STAGES-1];
   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;
   assign acc       = in_valid & en;
   assign busy      = |svld;
   assign idle      = ~busy & ~acc;
   assign idx_ok    = {1'b0, cfg_idx} < (IW+1)'(STAGES);
   assign cfg_ok    = cfg_we & idle & idx_ok;

   // Fold the updated table left to right: a force overrides, an invert flips bit 0
   // (pass<->invert, force-0<->force-1 under this encoding).
   always_comb begin
      red_nxt = OP_PASS;
      for (int k = 0; k < STAGES; k++) begin
         ops_nxt[k] = (cfg_ok && cfg_idx == IW'(k)) ? cfg_op : ops[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         if (ops_nxt[k][1])
            red_nxt = ops_nxt[k];
         else if (ops_nxt[k][0])
            red_nxt = {red_nxt[1], ~red_nxt[0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) ops[k] <= OP_PASS;
         red_op  <= OP_PASS;
         mode_q  <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we & ~cfg_ok;
         if (cfg_ok) begin
            for (int k = 0; k < STAGES; k++) ops[k] <= ops_nxt[k];
            red_op <= red_nxt;
         end
         if (idle)
            mode_q <= mode;
      end
   end

   // Stages past 0 are kept empty in reduced mode so busy only reflects live words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         svld <= '0;
         for (int k = 0; k < STAGES; k++) sdat[k] <= '0;
      end else if (en) begin
         svld[0] <= in_valid;
         sdat[0] <= apply_op(mode_q ? red_op : ops[0], in_data);
         for (int k = 1; k < STAGES; k++) begin
            svld[k] <= svld[k-1] & ~mode_q;
            sdat[k] <= apply_op(ops[k], sdat[k-1]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         xfer_cnt <= '0;
      else if (out_valid && out_ready && xfer_cnt != '1)
         xfer_cnt <= xfer_cnt + 1'b1;
   end

endmodule

// File: tb/tb_op_chain_pipe.sv
// Randomized bench for op_chain_pipe against a lane-wise chain model and a last-force/parity reduction model.
module tb_op_chain_pipe;
   // Five stages so that out-of-range indices exist on a 3-bit cfg_idx; small counter to reach saturation.
   localparam int W = 2;
   localparam int S = 5;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mode = 1'b0;
   logic cfg_we = 1'b0;
   logic [$clog2(S)-1:0] cfg_idx = '0;
   logic [1:0] cfg_op = 2'b00;
   logic cfg_err;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [W-1:0] in_data = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic busy;
   logic [C-1:0] xfer_cnt;

   op_chain_pipe #(.WIDTH(W), .STAGES(S), .CNTW(C)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_op(cfg_op), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [1:0] op_m [S];
   bit mode_m = 1'b0;
   int xfer_m = 0;
   logic [W-1:0] expq [$];
   logic [W-1:0] gotq [$];

   function automatic logic [W-1:0] ap(input logic [1:0] op, input logic [W-1:0] d);
      logic [W-1:0] r;
      for (int b = 0; b < W; b++) begin
         case (op)
            2'd0: r[b] = d[b];
            2'd1: r[b] = !d[b];
            2'd2: r[b] = 1'b0;
            default: r[b] = 1'b1;
         endcase
      end
      return r;
   endfunction

   function automatic logic [1:0] red_m();
      int last;
      int par;
      logic [1:0] base;
      last = -1;
      par = 0;
      for (int k = 0; k < S; k++) if (op_m[k] >= 2) last = k;
      base = (last < 0) ? 2'd0 : op_m[last];
      for (int k = last + 1; k < S; k++) if (op_m[k] == 2'd1) par = par + 1;
      if (par % 2 == 1) begin
         case (base)
            2'd0: base = 2'd1;
            2'd2: base = 2'd3;
            default: base = 2'd2;
         endcase
      end
      return base;
   endfunction

   function automatic logic [W-1:0] expect_out(input logic [W-1:0] d);
      logic [W-1:0] r;
      if (mode_m) return ap(red_m(), d);
      r = d;
      for (int k = 0; k < S; k++) r = ap(op_m[k], r);
      return r;
   endfunction

   function automatic void bump_xfer();
      if (xfer_m < (1 << C) - 1) xfer_m++;
   endfunction

   // One cycle of stimulus; records transfers and accepted words for later comparison.
   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
      in_valid = iv;
      in_data = d;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         gotq.push_back(out_data);
         bump_xfer();
      end
      if (iv && in_ready) expq.push_back(expect_out(d));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < S + 8 && gotq.size() < expq.size(); i++) step(1'b0, '0, 1'b1);
      in_valid = 1'b0;
   endtask

   // Presents one word to an idle pipe and reports the cycles until out_valid.
   task automatic measure(input logic [W-1:0] d, output int cyc, output logic [W-1:0] dat);
      bit seen;
      seen = 0;
      in_valid = 1'b1;
      in_data = d;
      out_ready = 1'b1;
      cyc = 0;
      dat = 'x;
      for (int i = 0; i < S + 5 && !seen; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         cyc++;
         if (out_valid) begin
            seen = 1;
            dat = out_data;
         end
      end
      if (seen) begin
         bump_xfer();
         @(posedge clk);
         #1;
      end else begin
         cyc = -1;
      end
   endtask

   task automatic set_mode(input bit m);
      mode = m;
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      mode_m = m;
   endtask

   task automatic cfg_write(input int idx, input logic [1:0] op);
      cfg_we = 1'b1;
      cfg_idx = 3'(idx);
      cfg_op = op;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      if (idx < S) op_m[idx] = op;
   endtask

   task automatic test_reset();
      #12;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
      if (xfer_cnt !== '0) begin errors++; $display("FAIL reset_xfer_cnt got %0d want 0", xfer_cnt); end
      if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %b want 00", out_data); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      int cyc;
      logic [W-1:0] dat;
      measure(2'b10, cyc, dat);
      checks += 3;
      if (cyc != S) begin errors++; $display("FAIL basic_latency got %0d want %0d", cyc, S); end
      if (dat !== 2'b10) begin errors++; $display("FAIL basic_data got %b want 10", dat); end
      if (xfer_cnt !== C'(1)) begin errors++; $display("FAIL basic_xfer got %0d want 1", xfer_cnt); end
   endtask

   task automatic test_invert_chain();
      int cyc;
      logic [W-1:0] dat;
      logic [1:0] prog [S] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      for (int k = 0; k < S; k++) cfg_write(k, prog[k]);
      set_mode(1'b0);
      measure(2'b01, cyc, dat);
      checks += 2;
      if (cyc != S) begin errors++; $display("FAIL inv_full_latency got %0d want %0d", cyc, S); end
      if (dat !== 2'b10) begin errors++; $display("FAIL inv_full_data got %b want 10", dat); end
      set_mode(1'b1);
      measure(2'b01, cyc, dat);
      checks += 2;
      if (cyc != 1) begin errors++; $display("FAIL inv_red_latency got %0d want 1", cyc); end
      if (dat !== 2'b10) begin errors++; $display("FAIL inv_red_data got %b want 10", dat); end
      set_mode(1'b0);
   endtask

   task automatic test_force_chain();
      int cyc;
      logic [W-1:0] dat;
      logic [1:0] prog [S] = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd0};
      for (int k = 0; k < S; k++) cfg_write(k, prog[k]);
      for (int m = 0; m < 2; m++) begin
         set_mode(m[0]);
         for (int d = 0; d < 4; d++) begin
            measure(W'(d), cyc, dat);
            checks += 2;
            if (cyc != (m == 0 ? S : 1)) begin
               errors++; $display("FAIL force_latency mode %0d in %0d got %0d", m, d, cyc);
            end
            if (dat !== 2'b11) begin
               errors++; $display("FAIL force_data mode %0d in %0d got %b want 11", m, d, dat);
            end
         end
      end
      set_mode(1'b0);
   endtask

   task automatic test_stall();
      logic [W-1:0] words [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      int wi;
      int stalls;
      bit prev_stall;
      logic [W-1:0] prev_dat;
      for (int k = 0; k < S; k++) cfg_write(k, 2'($urandom_range(0, 3)));
      wi = 0;
      stalls = 0;
      prev_stall = 0;
      prev_dat = '0;
      for (int c = 0; c < 60 && gotq.size() < 6; c++) begin
         in_valid = (wi < 6);
         in_data = words[wi % 6];
         out_ready = !(c >= S && c < S + 3);
         #1;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_dat) begin
               errors++; $display("FAIL stall_hold got %b/%b want 1/%b", out_valid, out_data, prev_dat);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_dat = out_data;
         if (prev_stall) begin
            stalls++;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
         end
         if (out_valid && out_ready) begin gotq.push_back(out_data); bump_xfer(); end
         if (in_valid && in_ready) begin expq.push_back(expect_out(words[wi])); wi++; end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks += 2;
      if (stalls != 3) begin errors++; $display("FAIL stall_cycles got %0d want 3", stalls); end
      if (gotq.size() != 6) begin errors++; $display("FAIL stall_count got %0d want 6", gotq.size()); end
      for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
         checks++;
         if (gotq[i] !== expq[i]) begin errors++; $display("FAIL stall_order idx %0d got %b want %b", i, gotq[i], expq[i]); end
      end
      gotq.delete();
      expq.delete();
      checks++;
      if (xfer_cnt !== C'(xfer_m)) begin errors++; $display("FAIL stall_xfer got %0d want %0d", xfer_cnt, xfer_m); end
   endtask

   task automatic test_cfg_err();
      step(1'b1, 2'($urandom), 1'b1);
      step(1'b1, 2'($urandom), 1'b1);
      cfg_we = 1'b1;
      cfg_idx = 3'd0;
      cfg_op = ~op_m[0];
      step(1'b1, 2'($urandom), 1'b1);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_busy_pulse got %b want 1", cfg_err); end
      step(1'b0, '0, 1'b1);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_busy_clear got %b want 0", cfg_err); end
      drain();
      cfg_write(5, ~op_m[0]);
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_idx_pulse got %b want 1", cfg_err); end
      step(1'b0, '0, 1'b1);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_idx_clear got %b want 0", cfg_err); end
      cfg_write(S - 1, op_m[S-1]);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_good_write got %b want 0", cfg_err); end
      for (int i = 0; i < 4; i++) step(1'b1, W'(i), 1'b1);
      drain();
      checks++;
      if (gotq.size() != expq.size()) begin errors++; $display("FAIL err_count got %0d want %0d", gotq.size(), expq.size()); end
      for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
         checks++;
         if (gotq[i] !== expq[i]) begin errors++; $display("FAIL err_table idx %0d got %b want %b", i, gotq[i], expq[i]); end
      end
      gotq.delete();
      expq.delete();
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < S; k++) cfg_write(k, 2'($urandom_range(0, 3)));
         set_mode(bit'($urandom_range(0, 1)));
         for (int i = 0; i < 25; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0));
         drain();
         checks++;
         if (gotq.size() != expq.size()) begin errors++; $display("FAIL rand_count round %0d got %0d want %0d", r, gotq.size(), expq.size()); end
         for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            checks++;
            if (gotq[i] !== expq[i]) begin errors++; $display("FAIL rand_data round %0d idx %0d got %b want %b", r, i, gotq[i], expq[i]); end
         end
         gotq.delete();
         expq.delete();
      end
      checks++;
      if (xfer_cnt !== C'(xfer_m)) begin errors++; $display("FAIL rand_xfer_sat got %0d want %0d", xfer_cnt, xfer_m); end
      set_mode(1'b0);
   endtask

   task automatic test_reset_midstream();
      int cyc;
      logic [W-1:0] dat;
      for (int k = 0; k < S; k++) cfg_write(k, 2'd1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom), 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      if (xfer_cnt !== '0) begin errors++; $display("FAIL midrst_xfer got %0d want 0", xfer_cnt); end
      for (int k = 0; k < S; k++) op_m[k] = 2'd0;
      mode_m = 0;
      xfer_m = 0;
      gotq.delete();
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      measure(2'b01, cyc, dat);
      checks += 3;
      if (cyc != S) begin errors++; $display("FAIL midrst_latency got %0d want %0d", cyc, S); end
      if (dat !== 2'b01) begin errors++; $display("FAIL midrst_data got %b want 01", dat); end
      if (xfer_cnt !== C'(1)) begin errors++; $display("FAIL midrst_xfer1 got %0d want 1", xfer_cnt); end
      set_mode(1'b1);
      measure(2'b10, cyc, dat);
      checks += 2;
      if (cyc != 1) begin errors++; $display("FAIL midrst_red_latency got %0d want 1", cyc); end
      if (dat !== 2'b10) begin errors++; $display("FAIL midrst_red_data got %b want 10", dat); end
   endtask

   initial begin
      for (int k = 0; k < S; k++) op_m[k] = 2'd0;
      test_reset();
      test_basic();
      test_invert_chain();
      test_force_chain();
      test_stall();
      test_cfg_err();
      test_random();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
